// File: rtl/fifo_uart_tx_reader.sv
// Read-side consumer of the async FIFO: pops one byte at a time and sends it as a UART frame.
// Build option: define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx_reader #(
   parameter int unsigned CLK_DIV = 16,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk_b,
   input  logic             rst,
   input  logic             tx_enable,
   input  logic             fifo_rempty,
   input  logic [7:0]       fifo_data,
   output logic             fifo_rd_en,
   output logic             txd,
   output logic             busy,
   output logic [CNT_W-1:0] frame_cnt
);

   localparam int unsigned BAUD_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE, S_POP, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_POP, S_WAIT, S_START, S_DATA, S_STOP
   } state_t;
`endif

   state_t            state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shreg_q, shreg_d;
   logic              parity_q, parity_d;
   logic              txd_q, txd_d;
   logic              rd_en_q, rd_en_d;
   logic              busy_q, busy_d;
   logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic              bit_last;

   assign bit_last = (baud_q == BAUD_LAST);

   // State register and registered outputs
   always_ff @(posedge clk_b or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         baud_q      <= '0;
         bit_idx_q   <= '0;
         shreg_q     <= '0;
         parity_q    <= 1'b0;
         txd_q       <= 1'b1;
         rd_en_q     <= 1'b0;
         busy_q      <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         parity_q    <= parity_d;
         txd_q       <= txd_d;
         rd_en_q     <= rd_en_d;
         busy_q      <= busy_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Next state; outputs are decoded from the next state so they line up with it after the edge
   always_comb begin
      state_d     = state_q;
      baud_d      = baud_q;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      parity_d    = parity_q;
      frame_cnt_d = frame_cnt_q;
      txd_d       = 1'b1;
      rd_en_d     = 1'b0;
      busy_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            baud_d    = '0;
            bit_idx_d = '0;
            if (tx_enable && !fifo_rempty) begin
               state_d = S_POP;
            end
         end
         S_POP: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            shreg_d  = fifo_data;
            parity_d = ^fifo_data;
            baud_d   = '0;
            state_d  = S_START;
         end
         S_START: begin
            if (bit_last) begin
               baud_d    = '0;
               bit_idx_d = '0;
               state_d   = S_DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         S_DATA: begin
            if (bit_last) begin
               baud_d  = '0;
               shreg_d = {1'b0, shreg_q[7:1]};
               if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
`ifdef UART_PARITY_EN
         S_PARITY: begin
            if (bit_last) begin
               baud_d  = '0;
               state_d = S_STOP;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
`endif
         S_STOP: begin
            if (bit_last) begin
               baud_d      = '0;
               frame_cnt_d = frame_cnt_q + CNT_W'(1);
               // Chain straight into the next pop when more data is waiting
               if (tx_enable && !fifo_rempty) begin
                  state_d = S_POP;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      rd_en_d = (state_d == S_POP);
      busy_d  = (state_d != S_IDLE);
      case (state_d)
         S_START:  txd_d = 1'b0;
         S_DATA:   txd_d = shreg_d[0];
`ifdef UART_PARITY_EN
         S_PARITY: txd_d = parity_d;
`endif
         default:  txd_d = 1'b1;
      endcase
   end

   assign fifo_rd_en = rd_en_q;
   assign txd        = txd_q;
   assign busy       = busy_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx_reader.sv
// Directed bench for fifo_uart_tx_reader with a small behavioural FIFO read port.
// Honours UART_PARITY_EN so the expected frames follow the build option.
module tb_fifo_uart_tx_reader;

   localparam int unsigned CLK_DIV = 4;
   localparam int unsigned CNT_W   = 3;
`ifdef UART_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic             clk_b = 1'b0;
   logic             rst = 1'b1;
   logic             tx_enable = 1'b0;
   logic             fifo_rempty;
   logic [7:0]       fifo_data = 8'h00;
   logic             fifo_rd_en;
   logic             txd;
   logic             busy;
   logic [CNT_W-1:0] frame_cnt;

   int checks = 0;
   int failures = 0;

   logic [7:0] mem [0:255];
   int wr_cnt = 0;
   int rd_cnt = 0;
   int pop_cnt = 0;
   int bad_pop = 0;

   fifo_uart_tx_reader #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) dut (
      .clk_b      (clk_b),
      .rst        (rst),
      .tx_enable  (tx_enable),
      .fifo_rempty(fifo_rempty),
      .fifo_data  (fifo_data),
      .fifo_rd_en (fifo_rd_en),
      .txd        (txd),
      .busy       (busy),
      .frame_cnt  (frame_cnt)
   );

   always #5 clk_b = ~clk_b;

   // FIFO read port model: registered data, valid the cycle after the pop
   assign fifo_rempty = (wr_cnt == rd_cnt);
   always @(posedge clk_b) begin
      if (fifo_rd_en) begin
         pop_cnt <= pop_cnt + 1;
         if (fifo_rempty) begin
            bad_pop <= bad_pop + 1;
         end else begin
            fifo_data <= mem[rd_cnt[7:0]];
            rd_cnt    <= rd_cnt + 1;
         end
      end
   end

   task automatic push(input logic [7:0] b);
      mem[wr_cnt[7:0]] = b;
      wr_cnt = wr_cnt + 1;
   endtask

   task automatic do_reset();
      @(negedge clk_b);
      rst = 1'b1;
      repeat (3) @(posedge clk_b);
      @(negedge clk_b);
      rst = 1'b0;
   endtask

   // Waits for the start bit, then checks every cycle of every bit; optionally drops tx_enable in one bit
   task automatic check_frame(input logic [7:0] b, input string name, input int drop_bit);
      logic [NBITS-1:0] exp;
      logic obs;
      bit ok;
      int budget;
      exp = '1;
      exp[0] = 1'b0;
      for (int i = 0; i < 8; i++) exp[i+1] = b[i];
`ifdef UART_PARITY_EN
      exp[9] = ^b;
`endif
      budget = 0;
      while (txd !== 1'b0 && budget < 200) begin
         @(negedge clk_b);
         budget++;
      end
      checks++;
      if (txd !== 1'b0) begin
         failures++;
         $display("FAIL %s_start_timeout got txd=%b exp=0", name, txd);
         return;
      end
      for (int k = 0; k < NBITS; k++) begin
         ok = 1'b1;
         obs = exp[k];
         for (int c = 0; c < int'(CLK_DIV); c++) begin
            if (!(k == 0 && c == 0)) @(negedge clk_b);
            if (k == drop_bit && c == 1) tx_enable = 1'b0;
            if (txd !== exp[k] || busy !== 1'b1) begin
               ok = 1'b0;
               obs = txd;
            end
         end
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL %s_bit%0d got txd=%b busy=%b exp txd=%b busy=1", name, k, obs, busy, exp[k]);
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk_b);
      @(negedge clk_b);
      checks++;
      if (txd !== 1'b1 || fifo_rd_en !== 1'b0 || busy !== 1'b0 || frame_cnt !== 3'd0) begin
         failures++;
         $display("FAIL reset_held got txd=%b rd_en=%b busy=%b cnt=%0d exp 1 0 0 0", txd, fifo_rd_en, busy, frame_cnt);
      end
      rst = 1'b0;
      repeat (5) @(negedge clk_b);
      checks++;
      if (txd !== 1'b1 || fifo_rd_en !== 1'b0 || busy !== 1'b0 || frame_cnt !== 3'd0) begin
         failures++;
         $display("FAIL reset_release got txd=%b rd_en=%b busy=%b cnt=%0d exp 1 0 0 0", txd, fifo_rd_en, busy, frame_cnt);
      end
   endtask

   task automatic test_single();
      int p0;
      do_reset();
      tx_enable = 1'b1;
      p0 = pop_cnt;
      push(8'hA5);
      @(negedge clk_b);
      checks++;
      if (fifo_rd_en !== 1'b1 || busy !== 1'b1 || txd !== 1'b1) begin
         failures++;
         $display("FAIL single_pop_cycle got rd_en=%b busy=%b txd=%b exp 1 1 1", fifo_rd_en, busy, txd);
      end
      @(negedge clk_b);
      checks++;
      if (fifo_rd_en !== 1'b0 || busy !== 1'b1 || txd !== 1'b1) begin
         failures++;
         $display("FAIL single_wait_cycle got rd_en=%b busy=%b txd=%b exp 0 1 1", fifo_rd_en, busy, txd);
      end
      @(negedge clk_b);
      checks++;
      if (txd !== 1'b0) begin
         failures++;
         $display("FAIL single_start_latency got txd=%b exp 0", txd);
      end
      check_frame(8'hA5, "single", -1);
      @(negedge clk_b);
      checks++;
      if (frame_cnt !== 3'd1 || pop_cnt - p0 != 1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL single_after got cnt=%0d pops=%0d busy=%b exp 1 1 0", frame_cnt, pop_cnt - p0, busy);
      end
   endtask

   task automatic test_idle_empty();
      bit bad;
      do_reset();
      tx_enable = 1'b1;
      bad = 1'b0;
      repeat (200) begin
         @(negedge clk_b);
         if (fifo_rd_en !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL idle_empty got activity=1 exp 0 (rd_en=%b txd=%b busy=%b)", fifo_rd_en, txd, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes [3];
      logic g1, g2, g3;
      bytes[0] = 8'h00;
      bytes[1] = 8'hFF;
      bytes[2] = 8'h55;
      do_reset();
      tx_enable = 1'b1;
      for (int i = 0; i < 3; i++) push(bytes[i]);
      for (int i = 0; i < 3; i++) begin
         check_frame(bytes[i], "b2b", -1);
         if (i < 2) begin
            @(negedge clk_b); g1 = txd;
            @(negedge clk_b); g2 = txd;
            @(negedge clk_b); g3 = txd;
            checks++;
            if (g1 !== 1'b1 || g2 !== 1'b1 || g3 !== 1'b0) begin
               failures++;
               $display("FAIL b2b_gap%0d got %b%b%b exp 110", i, g1, g2, g3);
            end
         end
      end
      @(negedge clk_b);
      checks++;
      if (frame_cnt !== 3'd3 || fifo_rempty !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL b2b_after got cnt=%0d empty=%b busy=%b exp 3 1 0", frame_cnt, fifo_rempty, busy);
      end
   endtask

   task automatic test_enable_drop();
      int p0;
      bit bad;
      do_reset();
      tx_enable = 1'b1;
      p0 = pop_cnt;
      push(8'h11);
      push(8'h0F);
      check_frame(8'h11, "drop", 4);
      bad = 1'b0;
      repeat (3 * CLK_DIV) begin
         @(negedge clk_b);
         if (fifo_rd_en !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad || frame_cnt !== 3'd1 || pop_cnt - p0 != 1 || fifo_rempty !== 1'b0) begin
         failures++;
         $display("FAIL drop_after got activity=%b cnt=%0d pops=%0d empty=%b exp 0 1 1 0", bad, frame_cnt, pop_cnt - p0, fifo_rempty);
      end
   endtask

   task automatic test_reset_mid();
      int budget;
      bit bad;
      tx_enable = 1'b1;
      budget = 0;
      while (txd !== 1'b0 && budget < 200) begin
         @(negedge clk_b);
         budget++;
      end
      repeat (CLK_DIV * 6 + 1) @(negedge clk_b);
      checks++;
      if (txd !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL midrst_bit5 got txd=%b busy=%b exp 0 1", txd, busy);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (txd !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0 || frame_cnt !== 3'd0) begin
         failures++;
         $display("FAIL midrst_async got txd=%b busy=%b rd_en=%b cnt=%0d exp 1 0 0 0", txd, busy, fifo_rd_en, frame_cnt);
      end
      repeat (3) @(posedge clk_b);
      @(negedge clk_b);
      rst = 1'b0;
      bad = 1'b0;
      repeat (50) begin
         @(negedge clk_b);
         if (fifo_rd_en !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad || fifo_rempty !== 1'b1) begin
         failures++;
         $display("FAIL midrst_after got activity=%b empty=%b exp 0 1", bad, fifo_rempty);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      tx_enable = 1'b1;
      for (int i = 0; i < 8; i++) push(8'(i * 8'h13 + 8'h01));
      for (int i = 0; i < 8; i++) begin
         check_frame(8'(i * 8'h13 + 8'h01), "wrap", -1);
         @(negedge clk_b);
         if (i >= 6) begin
            checks++;
            if (frame_cnt !== 3'(i + 1)) begin
               failures++;
               $display("FAIL wrap_cnt%0d got %0d exp %0d", i, frame_cnt, 3'(i + 1));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_idle_empty();
      test_back_to_back();
      test_enable_drop();
      test_reset_mid();
      test_wrap();
      checks++;
      if (bad_pop != 0) begin
         failures++;
         $display("FAIL pop_while_empty got %0d exp 0", bad_pop);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_uart_tx_reader.md
Name: fifo_uart_tx_reader

Overview:
- Single-clock read-side consumer for the team's 8-deep asynchronous FIFO. It lives in the FIFO's read clock domain.
- When the FIFO is non-empty it pops one byte, then serializes it onto a UART TX line: 1 start bit, 8 data bits LSB first, optional parity, 1 stop bit.
- It pairs with the FIFO write side (the producer) as the far end of the byte path.

Parameters:
- CLK_DIV, 16: clk_b cycles per UART bit. Legal range 2..65535.
- CNT_W, 16: width of the frame counter output.

Ports:
- clk_b  input  1  read-domain clock. All logic is on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- tx_enable  input  1  1 = allow popping and starting new frames.
- fifo_rempty  input  1  FIFO empty flag. Combinational on the FIFO side; sampled on clk_b.
- fifo_data  input  8  FIFO read data. Registered in the FIFO; valid the cycle after the rd_en pulse.
- fifo_rd_en  output  1  FIFO pop request. Exactly one clk_b cycle wide per byte.
- txd  output  1  UART serial out. Idle high.
- busy  output  1  high from the POP cycle through the end of STOP.
- frame_cnt  output  CNT_W  count of completed frames. Wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, rst=1): txd=1, fifo_rd_en=0, busy=0, frame_cnt=0, state=IDLE, shift register and counters cleared.
- Reset asserted mid-frame: txd returns high immediately. Any popped byte is discarded. The block restarts in IDLE after rst falls.
- All outputs are registered.
- State machine states: IDLE, POP, WAIT, START, DATA, PARITY (only with the macro), STOP.
- IDLE:
  - If tx_enable=1 and fifo_rempty=0, go to POP.
  - Otherwise stay in IDLE with txd=1 and busy=0.
- POP: fifo_rd_en=1 for this single cycle; busy=1; go to WAIT.
- WAIT:
  - fifo_data is valid in this cycle; load it into the shift register at the end of the cycle.
  - fifo_rd_en=0. Go to START.
  - fifo_rempty is ignored in this state.
- START: txd=0 for CLK_DIV cycles, then go to DATA.
- DATA:
  - Shift out 8 bits, LSB first, each held for CLK_DIV cycles.
  - A 3-bit bit index counts 0..7; after bit 7, go to PARITY or STOP.
- STOP:
  - txd=1 for CLK_DIV cycles. frame_cnt increments on the last cycle of STOP.
  - At the end of STOP: if tx_enable=1 and fifo_rempty=0, go directly to POP; otherwise go to IDLE.
- Baud divider: counts 0..CLK_DIV-1 and reloads at each bit boundary. Width is ceil(log2(CLK_DIV)).
- Latency: the decision edge in IDLE is cycle N; POP is cycle N+1, WAIT is N+2, and the first start-bit cycle is N+3.
- Frame length is 10*CLK_DIV cycles, or 11*CLK_DIV with parity.
- Back-to-back frames are separated by exactly 2 high cycles (POP, WAIT).
- Boundaries:
  - Never assert fifo_rd_en while fifo_rempty=1 is sampled.
  - tx_enable falling mid-frame: the current frame completes, then the block returns to IDLE with no further pop.
  - tx_enable is only checked in IDLE and at the end of STOP.
  - frame_cnt at 2^CNT_W-1 wraps to 0 on the next completed frame.

Optional Feature:
- Macro name: UART_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - txd = XOR of the 8 data bits (even parity), held for CLK_DIV cycles.
  - The frame is 11 bits long.
- When undefined:
  - No PARITY state exists; DATA goes directly to STOP.
  - The frame is 10 bits long.

Test Plan:
1. Assert rst for 3 cycles while clk_b runs -> txd=1, fifo_rd_en=0, busy=0, frame_cnt=0. Deassert -> outputs remain at these values while the FIFO is empty.
2. CLK_DIV=4, write 0xA5 into the FIFO, tx_enable=1 -> one fifo_rd_en pulse. txd shows 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. frame_cnt=1. With UART_PARITY_EN, a parity bit of 0 is inserted before the stop bit.
3. tx_enable=1 with the FIFO empty for 200 cycles -> fifo_rd_en never asserts, txd stays 1, busy stays 0.
4. CLK_DIV=4, write 0x00, 0xFF, 0x55 -> three frames with exactly 2 high cycles between each stop bit and the next start bit. frame_cnt=3, and the FIFO reports empty afterwards.
5. Two bytes queued; drop tx_enable during data bit 3 of the first frame -> the first frame completes correctly, no second fifo_rd_en, block returns to IDLE, frame_cnt=1.
6. Assert rst during data bit 5 -> txd=1 in the same cycle, busy=0. After release with the FIFO empty, there is no activity.
